tb_status_periph: RTL and testbench
===================================

# tb_status_periph

Memory-mapped testbench status peripheral sitting on the core's data bus inside the RISC-V simulation wrapper, directly upstream of the Verilator top's pass/fail/exit checks. It decodes firmware stores into a buffered stdout character stream, pass/fail flags and an exit code, and provides a readable cycle timer. Termination outputs are held back until the stdout buffer has drained, so no trailing text is lost when the bench calls `$finish`.

## Interface
- `BASE_ADDR`, `32'h1000_0000`: base of the 32-byte peripheral window; must be 32-byte aligned.
- `FIFO_DEPTH`, `8`: stdout buffer entries; must be a power of two, at least 2.
- `PASS_MAGIC`, `32'd123456789`: value that sets `tests_passed_o` when written to PASSFAIL.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `req_i`  in  1  bus request.
- `gnt_o`  out  1  bus grant; combinational.
- `addr_i`  in  32  byte address.
- `we_i`  in  1  write enable.
- `be_i`  in  4  byte enables.
- `wdata_i`  in  32  write data.
- `rvalid_o`  out  1  response valid.
- `rdata_o`  out  32  read data.
- `char_valid_o`  out  1  stdout stream valid.
- `char_o`  out  8  stdout character.
- `char_ready_i`  in  1  stdout consumer ready.
- `tests_passed_o`  out  1  sticky pass flag.
- `tests_failed_o`  out  1  sticky fail flag.
- `exit_valid_o`  out  1  sticky exit flag.
- `exit_value_o`  out  32  exit code.

## Operation
- Window hit: `addr_i[31:5] == BASE_ADDR[31:5]`. Offset register is `addr_i[4:2]`.
- Register map:
  - 0x00 STDOUT (W): push `wdata_i[7:0]` if `be_i[0]` is set.
  - 0x04 PASSFAIL (W): `PASS_MAGIC` requests pass; any other value requests fail.
  - 0x08 EXIT (W): request exit with `wdata_i`.
  - 0x0C TIMER (R): 32-bit free-running cycle count; wraps at 2^32.
  - 0x10 STATUS (R): bits [15:0] are the FIFO level; bit 16 means termination is pending.
- Unmapped offsets and non-hit addresses: writes are ignored, reads return 0. Write-only registers read as 0.
- Grant: `gnt_o = req_i`, except a STDOUT write while the FIFO is full gets `gnt_o = 0`; the core stalls until space frees.
- Full FIFO with a pop in the same cycle still counts as full, so the write is not granted that cycle.
- Simultaneous push and pop on a non-empty FIFO leaves the level unchanged.
- Termination FSM, 2-bit, states RUN, DRAIN, DONE:
  - RUN: an accepted PASSFAIL or EXIT write latches the request kind and value, then moves to DRAIN.
  - DRAIN: when FIFO level is 0 and no pop is in flight, assert the requested output and move to DONE.
  - DONE: absorbing. Further PASSFAIL, EXIT and STDOUT writes are granted and discarded.
- A second termination write while in DRAIN is granted and ignored; the first request wins.
- STDOUT writes during DRAIN are still enqueued and delay termination until drained.
- Reset mid-operation clears the FIFO, the FSM, all flags and the timer.

## Timing
- Reset values: `gnt_o` follows `req_i`; `rvalid_o=0`, `rdata_o=0`, `char_valid_o=0`, `char_o=0`, `tests_passed_o=0`, `tests_failed_o=0`, `exit_valid_o=0`, `exit_value_o=0`; FSM in RUN; timer 0.
- Read and write responses: `rvalid_o` pulses exactly one cycle after each grant.
- Read data: `rdata_o` is valid with `rvalid_o` and held until the next response.
- Stream handshake: `char_valid_o`/`char_o` come from the FIFO head, registered. A pop happens on `char_valid_o & char_ready_i`.
- Push-to-output latency: a character pushed into an empty FIFO appears on `char_valid_o` the cycle after the grant.
- Termination latency: with the FIFO empty, a termination write granted at cycle N asserts its flag at N+2 (N+1 latch to DRAIN, N+2 assert).
- Flags are sticky until reset.

## Structure
- Package `tb_periph_pkg`: register offset localparams, the `term_state_e` enum (RUN/DRAIN/DONE), the `term_kind_e` enum (PASS/FAIL/EXIT), and the default `PASS_MAGIC`.
- One sub-module: `tb_char_fifo`, a synchronous FIFO of parameterised depth with full/empty/level outputs.

## Test plan
- Write 'H','i','\n' to STDOUT with `char_ready_i=1` -> stream emits 0x48, 0x69, 0x0A in order; `rvalid_o` pulses once per write.
- Hold `char_ready_i=0` and issue 9 STDOUT writes with `FIFO_DEPTH=8` -> 9th write sees `gnt_o=0`; it is granted the cycle after `char_ready_i` rises.
- Buffer 3 chars with ready low, write EXIT=5, then raise ready -> `exit_valid_o` asserts only after the 3rd pop, with `exit_value_o=5`.
- Write PASSFAIL=123456789 with the FIFO empty -> `tests_passed_o=1` two cycles after grant. Write PASSFAIL=1 on a fresh run -> `tests_failed_o=1`.
- Read TIMER twice 10 cycles apart -> difference is 10. Read offset 0x14 -> returns 0.
- Assert `rst_ni` low during DRAIN -> all outputs return to reset values, FIFO level reads 0, FSM is in RUN.

Source files
------------

// File: rtl/tb_periph_pkg.sv
// Shared definitions for the simulation status peripheral: register offsets,
// termination FSM encodings and the default pass magic.
package tb_periph_pkg;

    localparam logic [2:0] OFF_STDOUT   = 3'd0;
    localparam logic [2:0] OFF_PASSFAIL = 3'd1;
    localparam logic [2:0] OFF_EXIT     = 3'd2;
    localparam logic [2:0] OFF_TIMER    = 3'd3;
    localparam logic [2:0] OFF_STATUS   = 3'd4;

    localparam logic [31:0] DEFAULT_PASS_MAGIC = 32'd123456789;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } term_state_e;

    typedef enum logic [1:0] {
        PASS = 2'd0,
        FAIL = 2'd1,
        EXIT = 2'd2
    } term_kind_e;

    function automatic logic [31:0] status_word(input logic [15:0] level, input logic pending);
        return {15'd0, pending, level};
    endfunction

endpackage

// File: rtl/tb_char_fifo.sv
// Synchronous character FIFO; the head is read straight from storage flops so
// the stream output is registered and forced to zero while empty.
module tb_char_fifo #(
    parameter int DEPTH = 8,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    head,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = empty ? 8'd0 : mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/tb_status_periph.sv
// Memory-mapped status peripheral: buffered stdout stream, pass/fail/exit
// reporting held back until stdout has drained, and a readable cycle timer.
//
// state | meaning
// RUN   | normal operation, waiting for a PASSFAIL or EXIT write
// DRAIN | termination latched, waiting for the stdout buffer to empty
// DONE  | requested flag asserted; later termination/stdout writes discarded
module tb_status_periph
    import tb_periph_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] PASS_MAGIC = DEFAULT_PASS_MAGIC
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        char_valid_o,
    output logic [7:0]  char_o,
    input  logic        char_ready_i,
    output logic        tests_passed_o,
    output logic        tests_failed_o,
    output logic        exit_valid_o,
    output logic [31:0] exit_value_o
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    term_state_e   state_q;
    term_state_e   state_d;
    term_kind_e    kind_q;
    term_kind_e    kind_d;
    logic [31:0]   value_q;
    logic [31:0]   timer_q;
    logic [31:0]   rdata_d;
    logic [LW-1:0] level;
    logic          full;
    logic          empty;
    logic          hit;
    logic [2:0]    off;
    logic          stdout_wr;
    logic          stall;
    logic          push;
    logic          pop;
    logic          term_wr;
    logic          latch_en;
    logic          assert_en;
    logic          unused_bits;

    assign unused_bits = ^{addr_i[1:0], be_i[3:1]};

    assign hit       = (addr_i[31:5] == BASE_ADDR[31:5]);
    assign off       = addr_i[4:2];
    assign stdout_wr = req_i & hit & we_i & (off == OFF_STDOUT);

    // Once terminated, stdout writes are discarded, so a full buffer no longer stalls.
    assign stall = stdout_wr & full & (state_q != DONE);
    assign gnt_o = req_i & ~stall;

    assign push    = stdout_wr & gnt_o & be_i[0] & (state_q != DONE);
    assign pop     = char_valid_o & char_ready_i;
    assign term_wr = gnt_o & hit & we_i & ((off == OFF_PASSFAIL) | (off == OFF_EXIT));

    assign char_valid_o = ~empty;

    tb_char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .LW    (LW)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push      (push),
        .push_data (wdata_i[7:0]),
        .pop       (pop),
        .head      (char_o),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    always_comb begin
        kind_d = FAIL;
        if (off == OFF_EXIT) begin
            kind_d = EXIT;
        end else if (wdata_i == PASS_MAGIC) begin
            kind_d = PASS;
        end
    end

    always_comb begin
        state_d   = state_q;
        latch_en  = 1'b0;
        assert_en = 1'b0;
        case (state_q)
            RUN: begin
                if (term_wr) begin
                    state_d  = DRAIN;
                    latch_en = 1'b1;
                end
            end
            DRAIN: begin
                // A same-cycle push would otherwise be lost behind the finish.
                if (empty && !pop && !push) begin
                    state_d   = DONE;
                    assert_en = 1'b1;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
            kind_q  <= PASS;
            value_q <= '0;
        end else begin
            state_q <= state_d;
            if (latch_en) begin
                kind_q  <= kind_d;
                value_q <= wdata_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tests_passed_o <= 1'b0;
            tests_failed_o <= 1'b0;
            exit_valid_o   <= 1'b0;
            exit_value_o   <= '0;
        end else if (assert_en) begin
            case (kind_q)
                PASS: tests_passed_o <= 1'b1;
                FAIL: tests_failed_o <= 1'b1;
                EXIT: begin
                    exit_valid_o <= 1'b1;
                    exit_value_o <= value_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + 32'd1;
        end
    end

    always_comb begin
        rdata_d = '0;
        if (hit && !we_i) begin
            case (off)
                OFF_TIMER:  rdata_d = timer_q;
                OFF_STATUS: rdata_d = status_word(16'(level), state_q == DRAIN);
                default:    rdata_d = '0;
            endcase
        end
    end

    // Every granted access gets a one-cycle response; writes return zero data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
        end else begin
            rvalid_o <= gnt_o;
            if (gnt_o) begin
                rdata_o <= rdata_d;
            end
        end
    end

endmodule

// File: tb/tb_tb_status_periph.sv
// Self-checking bench for tb_status_periph: directed scenarios plus a random
// phase checked against a queue-based model of the stdout stream and a cycle count.
module tb_tb_status_periph;
    localparam logic [31:0] BASE     = 32'h1000_0000;
    localparam int          DEPTH    = 8;
    localparam logic [31:0] MAGIC    = 32'd123456789;
    localparam logic [31:0] A_STDOUT = BASE + 32'h00;
    localparam logic [31:0] A_PF     = BASE + 32'h04;
    localparam logic [31:0] A_EXIT   = BASE + 32'h08;
    localparam logic [31:0] A_TIMER  = BASE + 32'h0C;
    localparam logic [31:0] A_STATUS = BASE + 32'h10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        gnt;
    logic [31:0] addr = '0;
    logic        we = 1'b0;
    logic [3:0]  be = '0;
    logic [31:0] wdata = '0;
    logic        rvalid;
    logic [31:0] rdata;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        ready = 1'b0;
    logic        passed;
    logic        failed;
    logic        exit_valid;
    logic [31:0] exit_value;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          rv_count = 0;
    int          n_resp = 0;
    logic [7:0]  q[$];
    bit          model_done = 1'b0;

    tb_status_periph #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH),
        .PASS_MAGIC (MAGIC)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_i          (req),
        .gnt_o          (gnt),
        .addr_i         (addr),
        .we_i           (we),
        .be_i           (be),
        .wdata_i        (wdata),
        .rvalid_o       (rvalid),
        .rdata_o        (rdata),
        .char_valid_o   (char_valid),
        .char_o         (char_data),
        .char_ready_i   (ready),
        .tests_passed_o (passed),
        .tests_failed_o (failed),
        .exit_valid_o   (exit_valid),
        .exit_value_o   (exit_value)
    );

    always #5 clk = ~clk;

    // Expected timer value: clock edges seen since reset was released.
    always @(posedge clk) begin
        if (rst_n) cyc <= cyc + 1;
        else       cyc <= 0;
    end

    always @(negedge clk) begin
        if (rvalid) rv_count <= rv_count + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Stream monitor: every handshake must deliver the oldest accepted character.
    always @(negedge clk) begin
        if (rst_n && char_valid && ready) begin
            if (q.size() == 0) check_eq("stream_extra_char", 32'(q.size()), 1);
            else               check_eq("stream_char", {24'd0, char_data}, {24'd0, q.pop_front()});
        end
    end

    // Called and returns at 1ns after a rising edge.
    task automatic bus_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] b, output logic [31:0] rd, output int gcyc,
                            output logic [2:0] fl);
        int n = 0;
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        rd = '0; gcyc = 0; fl = '0;
        @(negedge clk);
        while (!gnt && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (n == 4) ready = 1'b1;
            @(negedge clk);
        end
        if (!gnt) begin
            check_eq("grant_timeout", {31'd0, gnt}, 1);
            req = 1'b0; we = 1'b0;
            @(posedge clk); #1;
            return;
        end
        gcyc = cyc;
        if (w && a == A_STDOUT && b[0] && !model_done) q.push_back(d[7:0]);
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
        @(negedge clk);
        check_eq("rvalid_pulse", {31'd0, rvalid}, 1);
        rd = rdata;
        fl = {passed, failed, exit_valid};
        n_resp++;
        @(posedge clk); #1;
        check_eq("rvalid_single", {31'd0, rvalid}, 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; ready = 1'b0; we = 1'b0;
        req = 1'b1; addr = A_STATUS;
        @(negedge clk);
        check_eq("rst_gnt_follows_req", {31'd0, gnt}, 1);
        check_eq("rst_bits", {27'd0, rvalid, char_valid, passed, failed, exit_valid}, 0);
        check_eq("rst_rdata", rdata, 0);
        check_eq("rst_exit_value", exit_value, 0);
        check_eq("rst_char", {24'd0, char_data}, 0);
        @(posedge clk); #1;
        req = 1'b0;
        rst_n = 1'b1;
        q.delete();
        model_done = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (q.size() != 0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(q.size()), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] t1;
        logic [2:0]  fl;
        int          gc;
        int          gc1;
        int          n;
        string       msg;

        do_reset();

        // "Hi\n" with the consumer always ready
        ready = 1'b1;
        bus_xfer(1, A_STDOUT, 32'h48, 4'h1, rd, gc, fl);
        bus_xfer(1, A_STDOUT, 32'h69, 4'h1, rd, gc, fl);
        bus_xfer(1, A_STDOUT, 32'h0A, 4'h1, rd, gc, fl);
        wait_drain("hi_drained");

        // Fill the buffer, then a ninth write must stall until space frees
        ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) bus_xfer(1, A_STDOUT, 32'h30 + i, 4'h1, rd, gc, fl);
        bus_xfer(0, A_STATUS, 0, 4'hF, rd, gc, fl);
        check_eq("status_full_level", rd, 32'(DEPTH));
        req = 1'b1; we = 1'b1; addr = A_STDOUT; wdata = 32'h39; be = 4'h1;
        @(negedge clk);
        check_eq("full_stall", {31'd0, gnt}, 0);
        @(posedge clk); #1;
        ready = 1'b1;
        @(negedge clk);
        check_eq("full_pop_same_cycle_stall", {31'd0, gnt}, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("granted_after_ready", {31'd0, gnt}, 1);
        q.push_back(8'h39);
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
        @(negedge clk);
        check_eq("ninth_rvalid", {31'd0, rvalid}, 1);
        n_resp++;
        @(posedge clk); #1;
        wait_drain("full_drained");

        // Exit held back behind three buffered characters
        ready = 1'b0;
        for (int i = 0; i < 3; i++) bus_xfer(1, A_STDOUT, 32'h61 + i, 4'h1, rd, gc, fl);
        bus_xfer(1, A_EXIT, 32'd5, 4'hF, rd, gc, fl);
        bus_xfer(0, A_STATUS, 0, 4'hF, rd, gc, fl);
        check_eq("status_drain_pending", rd, 32'h0001_0003);
        check_eq("exit_held_back", {31'd0, exit_valid}, 0);
        ready = 1'b1;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (exit_valid) break;
            n++;
        end
        check_eq("exit_after_last_pop", 32'(n), 32'd4);
        check_eq("exit_queue_empty", 32'(q.size()), 0);
        check_eq("exit_value", exit_value, 32'd5);
        model_done = 1'b1;
        @(posedge clk); #1;
        bus_xfer(1, A_STDOUT, 32'h5A, 4'h1, rd, gc, fl);
        check_eq("done_stdout_discarded", {31'd0, char_valid}, 0);
        bus_xfer(1, A_PF, MAGIC, 4'hF, rd, gc, fl);
        check_eq("done_pf_discarded", {30'd0, passed, failed}, 0);
        bus_xfer(0, A_STATUS, 0, 4'hF, rd, gc, fl);
        check_eq("status_done", rd, 0);
        check_eq("exit_value_sticky", exit_value, 32'd5);

        // Pass with an empty buffer: flag two cycles after grant
        do_reset();
        bus_xfer(1, A_PF, MAGIC, 4'hF, rd, gc, fl);
        check_eq("pass_not_yet", {29'd0, fl}, 0);
        check_eq("pass_flags", {29'd0, passed, failed, exit_valid}, 32'b100);

        // Fail; a second termination write during drain is ignored
        do_reset();
        bus_xfer(1, A_STDOUT, 32'h78, 4'h1, rd, gc, fl);
        bus_xfer(1, A_PF, 32'd1, 4'hF, rd, gc, fl);
        bus_xfer(1, A_EXIT, 32'd9, 4'hF, rd, gc, fl);
        ready = 1'b1;
        n = 0;
        while (n < 20 && !failed) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        check_eq("fail_flags", {29'd0, passed, failed, exit_valid}, 32'b010);
        check_eq("fail_exit_value", exit_value, 0);

        // Timer and read decoding
        do_reset();
        bus_xfer(0, A_TIMER, 0, 4'hF, rd, gc1, fl);
        t1 = rd;
        check_eq("timer_value", t1, 32'(gc1));
        repeat (8) @(posedge clk);
        #1;
        check_eq("rdata_held", rdata, t1);
        bus_xfer(0, A_TIMER, 0, 4'hF, rd, gc, fl);
        check_eq("timer_delta", rd - t1, 32'd10);
        bus_xfer(0, BASE + 32'h14, 0, 4'hF, rd, gc, fl);
        check_eq("read_unmapped", rd, 0);
        bus_xfer(0, A_STDOUT, 0, 4'hF, rd, gc, fl);
        check_eq("read_write_only", rd, 0);
        bus_xfer(0, 32'h2000_000C, 0, 4'hF, rd, gc, fl);
        check_eq("read_miss", rd, 0);

        // Reset while draining
        ready = 1'b0;
        bus_xfer(1, A_STDOUT, 32'h41, 4'h1, rd, gc, fl);
        bus_xfer(1, A_STDOUT, 32'h42, 4'h1, rd, gc, fl);
        bus_xfer(1, A_EXIT, 32'd7, 4'hF, rd, gc, fl);
        do_reset();
        bus_xfer(0, A_STATUS, 0, 4'hF, rd, gc, fl);
        check_eq("status_after_reset", rd, 0);
        bus_xfer(1, A_PF, MAGIC, 4'hF, rd, gc, fl);
        check_eq("run_after_reset", {29'd0, passed, failed, exit_valid}, 32'b100);

        // Random traffic against the model
        do_reset();
        for (int it = 0; it < 120; it++) begin
            int          sel;
            logic [31:0] d;
            sel = $urandom_range(0, 9);
            d   = $urandom;
            if (sel <= 5) begin
                bus_xfer(1, A_STDOUT, d, (($urandom_range(0, 3) != 0) ? 4'h1 : 4'h0), rd, gc, fl);
            end else if (sel == 6) begin
                ready = ~ready;
                @(posedge clk); #1;
            end else if (sel == 7) begin
                bus_xfer(0, A_TIMER, 0, 4'hF, rd, gc, fl);
                check_eq("rand_timer", rd, 32'(gc));
            end else if (sel == 8) begin
                int lvl;
                ready = 1'b0;
                bus_xfer(0, A_STATUS, 0, 4'hF, rd, gc, fl);
                lvl = q.size();
                check_eq("rand_status", rd, 32'(lvl));
            end else begin
                msg = $sformatf("rand_unmapped_%0d", it);
                bus_xfer(0, BASE + 32'(4 * $urandom_range(5, 7)), 0, 4'hF, rd, gc, fl);
                check_eq(msg, rd, 0);
            end
        end
        ready = 1'b1;
        wait_drain("rand_drained");
        check_eq("rvalid_count", 32'(rv_count), 32'(n_resp));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
